multi_channel_counter: RTL and testbench

Parametrised N-channel up/down counter bank for stream-join bookkeeping (per-lane tuple credits, window occupancy, outstanding-request tracking). Each channel supports load, increment and decrement by run-time step sizes in the same cycle, with registered zero/threshold flags and sticky overflow/underflow indicators. It generalises the single-lane ±1 counter in width, channel count and step size, and adds optional saturation.

---
 rtl/multi_channel_counter_if.sv | 35 +++
 rtl/multi_channel_counter.sv | 100 ++++++++++
 tb/tb_multi_channel_counter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_channel_counter_if.sv
// Bundle of the per-channel control strobes, step values and registered status
// outputs of the multi_channel_counter bank. Clock and reset stay outside the
// bundle as plain ports.
interface multi_channel_counter_if #(
  parameter int C_WIDTH    = 16,
  parameter int C_CHANNELS = 4
);

  logic                            clken;
  logic [C_CHANNELS-1:0]           load;
  logic [C_CHANNELS*C_WIDTH-1:0]   load_value;
  logic [C_CHANNELS-1:0]           incr;
  logic [C_CHANNELS*C_WIDTH-1:0]   incr_step;
  logic [C_CHANNELS-1:0]           decr;
  logic [C_CHANNELS*C_WIDTH-1:0]   decr_step;
  logic [C_CHANNELS-1:0]           clr_flags;
  logic [C_CHANNELS*C_WIDTH-1:0]   count;
  logic [C_CHANNELS-1:0]           is_zero;
  logic [C_CHANNELS-1:0]           ge_thresh;
  logic [C_CHANNELS-1:0]           ovf;
  logic [C_CHANNELS-1:0]           unf;

  // Driver side: issues the strobes and observes the counts and flags.
  modport master (
    output clken, load, load_value, incr, incr_step, decr, decr_step, clr_flags,
    input  count, is_zero, ge_thresh, ovf, unf
  );

  // Counter bank side.
  modport slave (
    input  clken, load, load_value, incr, incr_step, decr, decr_step, clr_flags,
    output count, is_zero, ge_thresh, ovf, unf
  );

endinterface

// File: rtl/multi_channel_counter.sv
// N-channel up/down counter bank. Each channel can load, add and subtract
// run-time step sizes in one cycle, and keeps registered zero/threshold flags
// plus sticky overflow/underflow flags.
// Optional feature macro: MULTI_CHANNEL_COUNTER_SAT_EN -- when defined,
// out-of-range results clamp to the range limits; otherwise they wrap.
module multi_channel_counter #(
  parameter int                 C_WIDTH    = 16,
  parameter int                 C_CHANNELS = 4,
  parameter logic [C_WIDTH-1:0] C_INIT     = '0,
  parameter logic [C_WIDTH-1:0] C_THRESH   = {1'b1, {(C_WIDTH-1){1'b0}}}
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_channel_counter_if.slave bus
);

  // Two extra bits: one to hold a carry beyond the counter range, one as sign.
  localparam int SW = C_WIDTH + 2;

  logic [C_CHANNELS-1:0][C_WIDTH-1:0] count_q, count_d;
  logic [C_CHANNELS-1:0]              is_zero_q, is_zero_d;
  logic [C_CHANNELS-1:0]              ge_thresh_q, ge_thresh_d;
  logic [C_CHANNELS-1:0]              ovf_q, ovf_d;
  logic [C_CHANNELS-1:0]              unf_q, unf_d;
  logic [C_CHANNELS-1:0][SW-1:0]      sum;

  // Next-state computation for every channel: load, else net add/subtract.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    count_d     = count_q;
    is_zero_d   = is_zero_q;
    ge_thresh_d = ge_thresh_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    sum         = '0;
    for (int i = 0; i < C_CHANNELS; i++) begin
      if (bus.clken) begin
        // Clear first so a same-cycle event below re-sets the flag.
        ovf_d[i] = ovf_q[i] & ~bus.clr_flags[i];
        unf_d[i] = unf_q[i] & ~bus.clr_flags[i];
        if (bus.load[i]) begin
          count_d[i] = bus.load_value[i*C_WIDTH +: C_WIDTH];
        end else begin
          // Zero-extended operands; a set top bit means the result went negative.
          sum[i] = SW'(count_q[i])
                 + (bus.incr[i] ? SW'(bus.incr_step[i*C_WIDTH +: C_WIDTH]) : SW'(0))
                 - (bus.decr[i] ? SW'(bus.decr_step[i*C_WIDTH +: C_WIDTH]) : SW'(0));
          if (sum[i][SW-1]) begin
            unf_d[i] = 1'b1;
`ifdef MULTI_CHANNEL_COUNTER_SAT_EN
            count_d[i] = '0;
`else
            count_d[i] = sum[i][C_WIDTH-1:0];
`endif
          end else if (sum[i][C_WIDTH]) begin
            ovf_d[i] = 1'b1;
`ifdef MULTI_CHANNEL_COUNTER_SAT_EN
            count_d[i] = '1;
`else
            count_d[i] = sum[i][C_WIDTH-1:0];
`endif
          end else begin
            count_d[i] = sum[i][C_WIDTH-1:0];
          end
        end
        // Derived from the next count so the flags never lag the count.
        is_zero_d[i]   = (count_d[i] == '0);
        ge_thresh_d[i] = (count_d[i] >= C_THRESH);
      end
    end
  end

  // State registers with synchronous active-high reset; clken gating is in the
  // next-state logic.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      count_q     <= {C_CHANNELS{C_INIT}};
      is_zero_q   <= {C_CHANNELS{C_INIT == '0}};
      ge_thresh_q <= {C_CHANNELS{C_INIT >= C_THRESH}};
      ovf_q       <= '0;
      unf_q       <= '0;
    end else begin
      count_q     <= count_d;
      is_zero_q   <= is_zero_d;
      ge_thresh_q <= ge_thresh_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.is_zero   = is_zero_q;
  assign bus.ge_thresh = ge_thresh_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;

endmodule

// File: tb/tb_multi_channel_counter.sv
// Self-checking bench for multi_channel_counter: directed scenarios followed by
// randomized traffic, all compared against an integer-arithmetic model through
// a scoreboard queue. Honours MULTI_CHANNEL_COUNTER_SAT_EN for the expected
// out-of-range behaviour.
module tb_multi_channel_counter;

  localparam int W    = 4;
  localparam int NCH  = 4;
  localparam int INIT = 5;
  localparam int THR  = 8;
  localparam int MODV = 1 << W;
  localparam int MAXV = MODV - 1;

  typedef struct packed {
    logic [NCH*W-1:0] count;
    logic [NCH-1:0]   is_zero;
    logic [NCH-1:0]   ge_thresh;
    logic [NCH-1:0]   ovf;
    logic [NCH-1:0]   unf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  multi_channel_counter_if #(.C_WIDTH(W), .C_CHANNELS(NCH)) bus ();

  multi_channel_counter #(
    .C_WIDTH   (W),
    .C_CHANNELS(NCH),
    .C_INIT    (W'(INIT)),
    .C_THRESH  (W'(THR))
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model state: plain integers per channel.
  int m_cnt[NCH];
  bit m_ovf[NCH];
  bit m_unf[NCH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  function automatic exp_t model_step();
    exp_t e;
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        m_cnt[i] = INIT;
        m_ovf[i] = 0;
        m_unf[i] = 0;
      end else if (bus.clken) begin
        if (bus.clr_flags[i]) begin
          m_ovf[i] = 0;
          m_unf[i] = 0;
        end
        if (bus.load[i]) begin
          m_cnt[i] = int'(bus.load_value[i*W +: W]);
        end else begin
          int s;
          s = m_cnt[i];
          if (bus.incr[i]) s = s + int'(bus.incr_step[i*W +: W]);
          if (bus.decr[i]) s = s - int'(bus.decr_step[i*W +: W]);
          if (s > MAXV) begin
            m_ovf[i] = 1;
`ifdef MULTI_CHANNEL_COUNTER_SAT_EN
            s = MAXV;
`else
            s = s - MODV;
`endif
          end else if (s < 0) begin
            m_unf[i] = 1;
`ifdef MULTI_CHANNEL_COUNTER_SAT_EN
            s = 0;
`else
            s = s + MODV;
`endif
          end
          m_cnt[i] = s;
        end
      end
      e.count[i*W +: W] = W'(m_cnt[i]);
      e.is_zero[i]      = (m_cnt[i] == 0);
      e.ge_thresh[i]    = (m_cnt[i] >= THR);
      e.ovf[i]          = m_ovf[i];
      e.unf[i]          = m_unf[i];
    end
    return e;
  endfunction

  // Push the expectation for the coming edge, then step past it.
  task automatic cycle();
    exp_q.push_back(model_step());
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load       = '0;
    bus.incr       = '0;
    bus.decr       = '0;
    bus.clr_flags  = '0;
    bus.load_value = '0;
    bus.incr_step  = '0;
    bus.decr_step  = '0;
  endtask

  function automatic logic [W-1:0] ch_count(input int ch);
    logic [NCH*W-1:0] c;
    c = bus.count;
    return c[ch*W +: W];
  endfunction

  // Monitor: outputs are valid every cycle, so compare on each falling edge
  // for which an expectation is pending.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("count",     64'(bus.count),     64'(e.count));
      check("is_zero",   64'(bus.is_zero),   64'(e.is_zero));
      check("ge_thresh", 64'(bus.ge_thresh), 64'(e.ge_thresh));
      check("ovf",       64'(bus.ovf),       64'(e.ovf));
      check("unf",       64'(bus.unf),       64'(e.unf));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_v;
    rst       = 1'b1;
    bus.clken = 1'b0;
    idle_inputs();

    // Reset with clken low.
    bus.incr      = '1;
    bus.incr_step = {NCH{W'(1)}};
    cycle();
    check("reset_count", 64'(bus.count), 64'({NCH{W'(INIT)}}));
    check("reset_zero",  64'(bus.is_zero), 64'(0));
    check("reset_ge",    64'(bus.ge_thresh), 64'(0));
    check("reset_flags", 64'({bus.ovf, bus.unf}), 64'(0));

    // Load priority over increment on channel 1.
    rst       = 1'b0;
    bus.clken = 1'b1;
    idle_inputs();
    bus.load[1]           = 1'b1;
    bus.load_value[1*W +: W] = W'(9);
    bus.incr[1]           = 1'b1;
    bus.incr_step[1*W +: W]  = W'(3);
    cycle();
    check("load_ch1", 64'(ch_count(1)), 64'(9));
    check("load_ch0", 64'(ch_count(0)), 64'(INIT));
    check("load_ge1", 64'(bus.ge_thresh[1]), 64'(1));
    check("load_noflag", 64'({bus.ovf, bus.unf}), 64'(0));

    // Simultaneous increment and decrement on channel 0.
    idle_inputs();
    bus.load[0] = 1'b1;
    bus.load_value[0 +: W] = W'(7);
    cycle();
    idle_inputs();
    bus.incr[0] = 1'b1; bus.incr_step[0 +: W] = W'(4);
    bus.decr[0] = 1'b1; bus.decr_step[0 +: W] = W'(4);
    cycle();
    check("net_zero", 64'(ch_count(0)), 64'(7));
    bus.incr_step[0 +: W] = W'(2);
    bus.decr_step[0 +: W] = W'(5);
    cycle();
    check("net_minus3", 64'(ch_count(0)), 64'(4));

    // Overflow on channel 2, then the sticky flag across idle cycles.
    idle_inputs();
    bus.load[2] = 1'b1;
    bus.load_value[2*W +: W] = W'(14);
    cycle();
    idle_inputs();
    bus.incr[2] = 1'b1;
    bus.incr_step[2*W +: W] = W'(3);
    cycle();
`ifdef MULTI_CHANNEL_COUNTER_SAT_EN
    exp_v = 15;
`else
    exp_v = 1;
`endif
    check("ovf_count", 64'(ch_count(2)), 64'(exp_v));
    check("ovf_flag",  64'(bus.ovf[2]), 64'(1));
    idle_inputs();
    repeat (10) cycle();
    check("ovf_sticky", 64'(bus.ovf[2]), 64'(1));

    // Underflow on channel 3, clear, then clear racing a new underflow.
    bus.load[3] = 1'b1;
    bus.load_value[3*W +: W] = W'(2);
    cycle();
    idle_inputs();
    bus.decr[3] = 1'b1;
    bus.decr_step[3*W +: W] = W'(3);
    cycle();
`ifdef MULTI_CHANNEL_COUNTER_SAT_EN
    exp_v = 0;
`else
    exp_v = 15;
`endif
    check("unf_count", 64'(ch_count(3)), 64'(exp_v));
    check("unf_flag",  64'(bus.unf[3]), 64'(1));
    idle_inputs();
    bus.clr_flags[3] = 1'b1;
    cycle();
    check("unf_cleared", 64'(bus.unf[3]), 64'(0));
    idle_inputs();
    bus.load[3] = 1'b1;
    bus.load_value[3*W +: W] = W'(1);
    cycle();
    idle_inputs();
    bus.decr[3] = 1'b1;
    bus.decr_step[3*W +: W] = W'(3);
    bus.clr_flags[3] = 1'b1;
    cycle();
    check("unf_set_wins", 64'(bus.unf[3]), 64'(1));

    // Clock-enable gating: strobes while disabled are lost.
    idle_inputs();
    bus.clken     = 1'b0;
    bus.incr      = '1;
    bus.incr_step = {NCH{W'(1)}};
    bus.clr_flags = '1;
    repeat (5) cycle();
    bus.clr_flags = '0;
    bus.clken     = 1'b1;
    cycle();
    idle_inputs();

    // Randomized traffic with occasional reset and clock-enable drops.
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      bus.clken = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NCH; i++) begin
        bus.load[i]      = ($urandom_range(0, 7) == 0);
        bus.incr[i]      = $urandom_range(0, 1);
        bus.decr[i]      = $urandom_range(0, 1);
        bus.clr_flags[i] = ($urandom_range(0, 9) == 0);
        bus.load_value[i*W +: W] = W'($urandom_range(0, MAXV));
        bus.incr_step[i*W +: W]  = W'($urandom_range(0, MAXV));
        bus.decr_step[i*W +: W]  = W'($urandom_range(0, MAXV));
      end
      cycle();
    end
    rst = 1'b0;
    idle_inputs();

    // Let the monitor drain the scoreboard, bounded.
    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
